fir_out_conditioner: RTL and testbench
======================================

# fir_out_conditioner

Downstream stage of the 10-tap shift-add FIR: takes the raw 32-bit filter output each sample strobe, discards pipeline-fill samples, decimates, rescales with round-half-up, saturates to the output width and buffers results in a small FIFO with a valid/ready handshake toward the consumer. It isolates the free-running FIR from consumer back-pressure and reports clipping and overflow through sticky flags.

## Interface
- IN_W, 32: width of FIR output sample (signed two's complement)
- OUT_W, 16: width of conditioned output (signed)
- SHIFT, 8: arithmetic right-shift applied before saturation (0 = no shift, no rounding)
- DEC, 1: decimation factor (keep 1 of every DEC post-warm-up samples)
- WARMUP, 10: number of valid samples discarded after reset (FIR delay-line fill)
- DEPTH, 8: FIFO depth in entries (power of two)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- y_in  in  IN_W  FIR output sample
- in_valid  in  1  y_in is a new sample this cycle
- out_data  out  OUT_W  FIFO head (first-word-fall-through)
- out_valid  out  1  out_data holds a valid entry
- out_ready  in  1  consumer accepts head this cycle
- level  out  $clog2(DEPTH+1)  current FIFO occupancy
- sat_flag  out  1  sticky: at least one sample clipped
- drop_flag  out  1  sticky: at least one sample lost to FIFO full
- clr_flags  in  1  synchronous clear of sat_flag/drop_flag

## Operation
- Reset (async, rst_n=0): out_valid=0, out_data=0, level=0, sat_flag=0, drop_flag=0, warm-up counter=0, decimation phase=0, stage register invalid; FIFO contents discarded. Reset mid-operation restarts warm-up.
- Warm-up: first WARMUP samples with in_valid=1 ignored; counter saturates at WARMUP.
- Decimation: post-warm-up, phase counter 0..DEC-1 advances per valid sample, wraps; sample kept only when phase==0 (first post-warm-up sample always kept). DEC=1 keeps all.
- Scaling: sign-extend y_in to IN_W+1 bits; if SHIFT>0 add 2^(SHIFT-1); arithmetic shift right by SHIFT (round half toward +inf). Never overflows internally.
- Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; clamp event sets sat_flag.
- Stage register: kept sample's conditioned value and stage_valid registered at the edge after acceptance.
- FIFO write: when stage_valid=1. Full and no simultaneous pop -> sample dropped, drop_flag set, contents unchanged. Full with simultaneous pop -> both succeed, level unchanged.
- FIFO read: pop when out_valid=1 and out_ready=1; out_ready with out_valid=0 is ignored. Empty with simultaneous push: no pop, level becomes 1.
- Pointers wrap modulo DEPTH; order strictly preserved.
- clr_flags=1 clears both flags at the edge; a set event in the same cycle wins (flag stays 1).

## Timing
- Sample with in_valid=1 in cycle N (kept): stage_valid=1 in N+1, FIFO written at end of N+1, out_valid=1 with data in N+2 if FIFO was empty. Latency 2 cycles.
- Throughput: one sample per cycle accepted, one popped per cycle.
- level updates at the edge of push/pop; out_valid = (level != 0), registered.
- sat_flag asserts cycle N+1 for a clipped sample accepted in N; drop_flag asserts the cycle after the failed write.

## Test plan
- Warm-up: reset, SHIFT=8, DEC=1, feed y_in=k*256 for k=1..12 every cycle -> exactly two outputs, 11 then 12; first out_valid 2 cycles after the 11th sample.
- Rounding: y_in=384 -> 2; y_in=-384 (0xFFFFFE80) -> -1; y_in=127 -> 0; y_in=128 -> 1; sat_flag stays 0.
- Saturation: y_in=0x7FFFFFFF -> 32767, y_in=0x80000000 -> -32768; sat_flag=1; clr_flags pulse -> 0.
- Decimation DEC=3: post-warm-up y_in=k*256, k=1..9 -> outputs 1, 4, 7.
- Back-pressure: out_ready=0, 10 kept samples 1..10 -> level=8, drop_flag=1, FIFO holds 1..8; then out_ready=1 -> 1..8 out on consecutive cycles, level=0, out_valid=0. Full with simultaneous push/pop keeps level=8, no drop.
- Reset mid-stream: rst_n low with level=5 -> out_valid=0, level=0 immediately (async); after release, next 10 valid samples discarded again.

Source files
------------

// File: rtl/fir_out_conditioner_if.sv
// Sample-in / conditioned-sample-out bundle for fir_out_conditioner.
// The master side is the FIR source plus the consumer. The slave side is the conditioner.
interface fir_out_conditioner_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int DEPTH = 8
) ();
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [IN_W-1:0]  y_in;
  logic             in_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LVL_W-1:0] level;
  logic             sat_flag;
  logic             drop_flag;
  logic             clr_flags;

  modport master (
    output y_in, in_valid, out_ready, clr_flags,
    input  out_data, out_valid, level, sat_flag, drop_flag
  );

  modport slave (
    input  y_in, in_valid, out_ready, clr_flags,
    output out_data, out_valid, level, sat_flag, drop_flag
  );
endinterface

// File: rtl/fir_out_conditioner.sv
// Post-FIR conditioner. It performs these steps in order:
//   1. drops the delay-line fill samples;
//   2. decimates;
//   3. rescales with round-half-up and saturates;
//   4. buffers results in a first-word-fall-through FIFO with valid/ready toward the consumer.
// Sticky flags report clipping and FIFO overflow.
module fir_out_conditioner #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 8,
  parameter int DEC    = 1,
  parameter int WARMUP = 10,
  parameter int DEPTH  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  fir_out_conditioner_if.slave bus
);
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PH_W   = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int EXT_W  = IN_W + 1;

  localparam logic [EXT_W-1:0] ONE = EXT_W'(1);
  // Half an LSB of the shifted result. This is zero when SHIFT is 0.
  localparam logic [EXT_W-1:0] RND = (ONE << SHIFT) >> 1;
  localparam logic signed [EXT_W-1:0] MAXV = signed'((ONE << (OUT_W - 1)) - ONE);
  localparam logic signed [EXT_W-1:0] MINV = signed'(~((ONE << (OUT_W - 1)) - ONE));

  logic [WCNT_W-1:0] warm_q, warm_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              stage_valid_q, stage_valid_d;
  logic [OUT_W-1:0]  stage_data_q, stage_data_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              out_valid_q, out_valid_d;
  logic              sat_q, sat_d;
  logic              drop_q, drop_d;
  logic [OUT_W-1:0]  mem_q [DEPTH];

  logic                    warm_done, keep, clip, push, pop, full;
  logic signed [EXT_W-1:0] rounded, shifted;
  logic [OUT_W-1:0]        cond;

  // Widen by one bit so adding the rounding constant cannot overflow. Then shift and clamp.
  always_comb begin
    rounded = signed'({bus.y_in[IN_W-1], bus.y_in}) + signed'(RND);
    shifted = rounded >>> SHIFT;
    clip    = 1'b0;
    cond    = shifted[OUT_W-1:0];
    if (shifted > MAXV) begin
      cond = MAXV[OUT_W-1:0];
      clip = 1'b1;
    end else if (shifted < MINV) begin
      cond = MINV[OUT_W-1:0];
      clip = 1'b1;
    end
  end

  // Next-state logic for the warm-up, decimation, stage, FIFO and flag registers.
  always_comb begin
    warm_done = (warm_q == WCNT_W'(WARMUP));
    keep      = bus.in_valid && warm_done && (phase_q == '0);
    pop       = out_valid_q && bus.out_ready;
    full      = (level_q == LVL_W'(DEPTH));
    push      = stage_valid_q && (!full || pop);

    warm_d = warm_q;
    if (bus.in_valid && !warm_done) warm_d = warm_q + WCNT_W'(1);

    phase_d = phase_q;
    if (bus.in_valid && warm_done)
      phase_d = (phase_q == PH_W'(DEC - 1)) ? '0 : phase_q + PH_W'(1);

    stage_valid_d = keep;
    stage_data_d  = keep ? cond : stage_data_q;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    out_valid_d = (level_d != '0);

    // A clear that coincides with a new event leaves the flag set.
    sat_d = bus.clr_flags ? 1'b0 : sat_q;
    if (keep && clip) sat_d = 1'b1;
    drop_d = bus.clr_flags ? 1'b0 : drop_q;
    if (stage_valid_q && !push) drop_d = 1'b1;
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q        <= '0;
      phase_q       <= '0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      sat_q         <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      warm_q        <= warm_d;
      phase_q       <= phase_d;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      sat_q         <= sat_d;
      drop_q        <= drop_d;
    end
  end

  // FIFO storage. It needs no reset because the pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= stage_data_q;
  end

  assign bus.out_data  = out_valid_q ? mem_q[rd_ptr_q] : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.level     = level_q;
  assign bus.sat_flag  = sat_q;
  assign bus.drop_flag = drop_q;
endmodule

// File: tb/tb_fir_out_conditioner.sv
// Bench for fir_out_conditioner. Two instances (DEC=1 and DEC=3) get identical stimulus.
// Each instance is compared every cycle against a queue-based reference model.
module tb_fir_out_conditioner;
  localparam int DEPTH  = 8;
  localparam int WARMUP = 10;
  localparam int S      = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_out_conditioner_if #(.IN_W(32), .OUT_W(16), .DEPTH(DEPTH)) if1 ();
  fir_out_conditioner_if #(.IN_W(32), .OUT_W(16), .DEPTH(DEPTH)) if3 ();

  fir_out_conditioner #(.IN_W(32), .OUT_W(16), .SHIFT(S), .DEC(1), .WARMUP(WARMUP), .DEPTH(DEPTH))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  fir_out_conditioner #(.IN_W(32), .OUT_W(16), .SHIFT(S), .DEC(3), .WARMUP(WARMUP), .DEPTH(DEPTH))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  logic [15:0] od [2];
  logic        ov [2];
  logic [3:0]  lv [2];
  logic        sf [2];
  logic        df [2];
  assign od[0] = if1.out_data;  assign od[1] = if3.out_data;
  assign ov[0] = if1.out_valid; assign ov[1] = if3.out_valid;
  assign lv[0] = if1.level;     assign lv[1] = if3.level;
  assign sf[0] = if1.sat_flag;  assign sf[1] = if3.sat_flag;
  assign df[0] = if1.drop_flag; assign df[1] = if3.drop_flag;

  // Reference model state, one slot per instance.
  int mq [2][$];
  int decs [2] = '{1, 3};
  int warm [2];
  int ph [2];
  bit stv [2];
  int stdat [2];
  bit msat [2];
  bit mdrop [2];
  int obs [2][$];
  int expq [$];
  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic signed [63:0] act, logic signed [63:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // The conditioning rule stated with plain arithmetic: floor((y + 2^(S-1)) / 2^S), then clamp.
  function automatic int scale(logic [31:0] y, output bit clip);
    longint v = longint'($signed(y));
    longint d = longint'(1) << S;
    longint qv;
    v  = v + d / 2;
    qv = v / d;
    if ((v % d) != 0 && v < 0) qv = qv - 1;
    clip = 1'b0;
    if (qv > 32767) begin qv = 32767; clip = 1'b1; end
    else if (qv < -32768) begin qv = -32768; clip = 1'b1; end
    return int'(qv);
  endfunction

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      warm[m] = 0; ph[m] = 0; stv[m] = 1'b0; stdat[m] = 0;
      msat[m] = 1'b0; mdrop[m] = 1'b0;
    end
  endtask

  task automatic model_edge(int m, logic [31:0] y, bit v, bit rdy, bit clr);
    bit sat_ev = 1'b0;
    bit drop_ev = 1'b0;
    bit c;
    if (rdy && mq[m].size() != 0) void'(mq[m].pop_front());
    if (stv[m]) begin
      if (mq[m].size() < DEPTH) mq[m].push_back(stdat[m]);
      else drop_ev = 1'b1;
    end
    stv[m] = 1'b0;
    if (v) begin
      if (warm[m] < WARMUP) warm[m]++;
      else begin
        if (ph[m] == 0) begin
          stv[m] = 1'b1;
          stdat[m] = scale(y, c);
          sat_ev = c;
        end
        ph[m] = (ph[m] + 1) % decs[m];
      end
    end
    if (clr) begin msat[m] = 1'b0; mdrop[m] = 1'b0; end
    if (sat_ev) msat[m] = 1'b1;
    if (drop_ev) mdrop[m] = 1'b1;
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("out_valid[%0d]", m), ov[m], (mq[m].size() != 0));
      chk($sformatf("level[%0d]", m), lv[m], mq[m].size());
      chk($sformatf("out_data[%0d]", m), $signed(od[m]), (mq[m].size() != 0) ? mq[m][0] : 0);
      chk($sformatf("sat_flag[%0d]", m), sf[m], msat[m]);
      chk($sformatf("drop_flag[%0d]", m), df[m], mdrop[m]);
    end
  endtask

  task automatic chk_obs(string tag, int m);
    chk({tag, "_count"}, obs[m].size(), expq.size());
    for (int i = 0; i < expq.size() && i < obs[m].size(); i++)
      chk($sformatf("%s_%0d", tag, i), obs[m][i], expq[i]);
  endtask

  // One clock cycle: drive at the falling edge, log handshakes, then check after the rising edge.
  task automatic cycle(logic [31:0] y, bit v, bit rdy, bit clr);
    if1.y_in = y; if1.in_valid = v; if1.out_ready = rdy; if1.clr_flags = clr;
    if3.y_in = y; if3.in_valid = v; if3.out_ready = rdy; if3.clr_flags = clr;
    #1;
    for (int m = 0; m < 2; m++)
      if (ov[m] && rdy) obs[m].push_back(int'($signed(od[m])));
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) model_edge(m, y, v, rdy, clr);
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) cycle(32'd0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    if1.in_valid = 1'b0; if3.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid1", ov[0], 1'b0);
    chk("async_rst_level1", lv[0], 0);
    chk("async_rst_valid3", ov[1], 1'b0);
    chk("async_rst_level3", lv[1], 0);
    mreset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] y;
    if1.y_in = '0; if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.clr_flags = 1'b0;
    if3.y_in = '0; if3.in_valid = 1'b0; if3.out_ready = 1'b0; if3.clr_flags = 1'b0;
    mreset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Warm-up: only samples 11 and 12 survive.
    obs[0].delete(); obs[1].delete();
    for (int k = 1; k <= 12; k++) cycle(32'(k * 256), 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);
    expq = {11, 12}; chk_obs("warmup_dec1", 0);
    expq = {11};     chk_obs("warmup_dec3", 1);

    // Round half toward +inf.
    obs[0].delete();
    cycle(32'd384, 1'b1, 1'b1, 1'b0);
    cycle(32'hFFFF_FE80, 1'b1, 1'b1, 1'b0);
    cycle(32'd127, 1'b1, 1'b1, 1'b0);
    cycle(32'd128, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);
    expq = {2, -1, 0, 1}; chk_obs("rounding", 0);
    chk("round_no_sat", sf[0], 1'b0);

    // Saturation at both rails, then clear the flag.
    obs[0].delete();
    cycle(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    cycle(32'h8000_0000, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);
    expq = {32767, -32768}; chk_obs("saturate", 0);
    chk("sat_set", sf[0], 1'b1);
    cycle(32'd0, 1'b0, 1'b1, 1'b1);
    chk("sat_cleared", sf[0], 1'b0);

    // Decimation after a fresh reset.
    do_reset();
    for (int k = 0; k < WARMUP; k++) cycle(32'd0, 1'b1, 1'b1, 1'b0);
    obs[0].delete(); obs[1].delete();
    for (int k = 1; k <= 9; k++) cycle(32'(k * 256), 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);
    expq = {1, 4, 7}; chk_obs("decimate3", 1);
    expq.delete(); for (int k = 1; k <= 9; k++) expq.push_back(k);
    chk_obs("decimate1", 0);

    // Back-pressure overflow, then drain.
    for (int k = 1; k <= 10; k++) cycle(32'(k * 256), 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("bp_level_full", lv[0], 8);
    chk("bp_drop_set", df[0], 1'b1);
    obs[0].delete();
    idle(10, 1'b1);
    expq.delete(); for (int k = 1; k <= 8; k++) expq.push_back(k);
    chk_obs("bp_drain", 0);
    chk("bp_level_empty", lv[0], 0);
    chk("bp_valid_empty", ov[0], 1'b0);

    // Full FIFO with a simultaneous push and pop.
    cycle(32'd0, 1'b0, 1'b1, 1'b1);
    for (int k = 21; k <= 29; k++) cycle(32'(k * 256), 1'b1, 1'b0, 1'b0);
    chk("pp_level_full", lv[0], 8);
    for (int k = 30; k <= 33; k++) cycle(32'(k * 256), 1'b1, 1'b1, 1'b0);
    chk("pp_level_hold", lv[0], 8);
    chk("pp_no_drop", df[0], 1'b0);
    idle(12, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      y = $urandom;
      if ($urandom_range(0, 1) == 1) y = {{8{y[23]}}, y[23:0]};
      cycle(y, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    // Reset with a partly filled FIFO restarts warm-up.
    idle(12, 1'b1);
    cycle(32'd0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) cycle(32'(k * 256), 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("mid_level5", lv[0], 5);
    do_reset();
    obs[0].delete(); obs[1].delete();
    for (int k = 1; k <= 12; k++) cycle(32'(k * 256), 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);
    expq = {11, 12}; chk_obs("rewarm", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
